dmem_copy_engine: RTL and testbench
===================================

Name: dmem_copy_engine

Overview:
- Block-copy engine that sits directly upstream of the data memory.
- Owns the memory's single address port, write enable and write-data input. Multiplexes the CPU core's load/store traffic with an internal copy state machine.
- On Start, copies Len bytes from SrcAddr to DstAddr inside data memory. The core is stalled while the copy runs.

Parameters:
AW, 8, address width (memory depth 2**AW = 256)
DW, 8, data width
LW, 9, length width (encodes 0..256 bytes)

Ports:
Clk  in  1  clock; all state updates on posedge
Reset  in  1  synchronous, active-high reset
Start  in  1  copy request; sampled only in IDLE
SrcAddr  in  AW  first source byte address
DstAddr  in  AW  first destination byte address
Len  in  LW  byte count, 0..256
CoreAddr  in  AW  core load/store address
CoreWrEn  in  1  core store enable
CoreDataIn  in  DW  core store data
CoreDataOut  out  DW  load data to core (= MemDataOut, combinational)
Stall  out  1  core must hold; asserted whenever Busy
Busy  out  1  state != IDLE
Done  out  1  one-cycle pulse when a copy completes
MemAddr  out  AW  to data memory DataAddress
MemWriteEn  out  1  to data memory WriteEn
MemDataIn  out  DW  to data memory DataIn
MemDataOut  in  DW  from data memory DataOut (combinational read)

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - state=IDLE; src_ptr, dst_ptr, count and buf cleared.
  - Busy=0, Done=0, Stall=0.
- Reset mid-copy: abort immediately, no further writes. Bytes already written stay in memory. Done is not pulsed.
- States: IDLE, READ, WRITE, DONE (enum).
- IDLE:
  - Memory-side outputs pass the core through: MemAddr=CoreAddr, MemWriteEn=CoreWrEn, MemDataIn=CoreDataIn.
  - On Start=1: latch SrcAddr, DstAddr, Len. Go to DONE if Len==0, else READ.
  - A core access presented in the same cycle as Start still executes, because routing is combinational on the IDLE state.
- READ:
  - MemAddr=src_ptr, MemWriteEn=0.
  - At posedge: buf<=MemDataOut, src_ptr<=src_ptr+1 (mod 256). Go to WRITE.
- WRITE:
  - MemAddr=dst_ptr, MemWriteEn=1, MemDataIn=buf.
  - At posedge: dst_ptr<=dst_ptr+1 (mod 256), count<=count-1.
  - Go to DONE if count==1, else READ.
- DONE: Done=1 for exactly this cycle, no memory write. Go to IDLE.
- Outputs by state:
  - MemWriteEn=0 in READ and DONE.
  - Core CoreWrEn/CoreAddr are ignored in every non-IDLE state.
  - CoreDataOut always mirrors MemDataOut; it is meaningful to the core only when Stall=0.
- Latency: Done asserts 2*Len+1 cycles after the Start edge (Len=0 gives 1 cycle). Busy stays high through the DONE cycle.
- Start while Busy: ignored, not queued.
- Address wrap: pointers wrap modulo 256. A 256-byte copy covers the whole memory.
- Overlap: copy is strictly ascending and byte-serial.
  - If dst lies in (src, src+Len), source bytes are overwritten before they are read; the result is a repeating pattern. This is defined behaviour, not an error.
  - src==dst rewrites identical data.
- Len>256 cannot be encoded; the LW=9 upper bound is 256.

Decomposition:
- Shared package holds:
  - state enum (IDLE, READ, WRITE, DONE)
  - localparams for AW, DW, LW defaults
- Single module: address/data mux plus a small FSM. No sub-module is needed.
- The data memory is instantiated at the top level and wired via the Mem* ports.

Test Plan:
- Core pass-through: idle; core store 0x5A to 0x10, then load 0x10 -> MemWriteEn follows CoreWrEn, CoreDataOut=0x5A, Stall=0.
- Basic copy: preload 0x20..0x23 = 11,22,33,44; Start, Src=0x20, Dst=0x80, Len=4 -> 0x80..0x83 = 11,22,33,44; Done pulses exactly 9 cycles after Start; Busy=1 over that window.
- Zero length: Start with Len=0 -> Done on the next cycle, no MemWriteEn assertion, memory unchanged.
- Wrap and overlap:
  - Src=0xFE, Dst=0x10, Len=4 -> reads 0xFE,0xFF,0x00,0x01 in order.
  - Src=0x40, Dst=0x41, Len=3, with mem[0x40]=0xAB -> 0x41..0x43 all 0xAB.
- Stall/ignore: during a copy, drive CoreWrEn=1 to 0x90 and pulse Start again -> no write to 0x90, no second copy, Stall=1 until Done+1.
- Reset mid-copy: assert Reset after the 2nd WRITE of a Len=8 copy -> exactly 2 destination bytes changed, Busy=0 and Done=0 next cycle, core access works immediately.

Source files
------------

// File: rtl/dmem_copy_engine_pkg.sv
// rtl/dmem_copy_engine_pkg.sv - shared types and default widths for the data-memory copy engine
package dmem_copy_engine_pkg;

  // Default widths: 256-byte memory, byte data, length field able to encode 0..256
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int LW_DEF = 9;

  // Copy sequencer states; IDLE is the only state in which the core owns the memory port
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_copy_engine_if.sv
// rtl/dmem_copy_engine_if.sv - single-port data memory bus (address, write enable, write data, read data)
interface dmem_copy_engine_if
  import dmem_copy_engine_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic [AW-1:0] addr;      // byte address
  logic          wr_en;     // store enable, committed at posedge
  logic [DW-1:0] data_in;   // store data towards the memory
  logic [DW-1:0] data_out;  // combinational read data from the memory

  // Requester side: issues address/stores, receives read data
  modport master (
    output addr,
    output wr_en,
    output data_in,
    input  data_out
  );

  // Responder side: accepts address/stores, returns read data
  modport slave (
    input  addr,
    input  wr_en,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/dmem_copy_engine.sv
// rtl/dmem_copy_engine.sv - muxes core load/store traffic with a byte-serial block-copy sequencer
module dmem_copy_engine
  import dmem_copy_engine_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [AW-1:0]         src_addr_i,
  input  logic [AW-1:0]         dst_addr_i,
  input  logic [LW-1:0]         len_i,
  dmem_copy_engine_if.slave     core,
  dmem_copy_engine_if.master    mem,
  output logic                  stall_o,
  output logic                  busy_o,
  output logic                  done_o
);

  state_e        state_q;
  logic [AW-1:0] src_ptr_q;
  logic [AW-1:0] dst_ptr_q;
  logic [LW-1:0] count_q;
  logic [DW-1:0] buf_q;
  logic          busy_q;
  logic          done_q;

  // Copy sequencer: alternates READ/WRITE per byte; busy/done are registered alongside the state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      count_q   <= '0;
      buf_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            src_ptr_q <= src_addr_i;
            dst_ptr_q <= dst_addr_i;
            count_q   <= len_i;
            busy_q    <= 1'b1;
            if (len_i == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          buf_q     <= mem.data_out;
          src_ptr_q <= src_ptr_q + 1'b1;
          state_q   <= ST_WRITE;
        end
        ST_WRITE: begin
          dst_ptr_q <= dst_ptr_q + 1'b1;
          count_q   <= count_q - 1'b1;
          if (count_q == LW'(1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_READ;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Memory port routing: core passes straight through in IDLE so a store in the Start cycle still lands
  always_comb begin
    mem.addr    = core.addr;
    mem.wr_en   = core.wr_en;
    mem.data_in = core.data_in;
    case (state_q)
      ST_READ: begin
        mem.addr    = src_ptr_q;
        mem.wr_en   = 1'b0;
        mem.data_in = buf_q;
      end
      ST_WRITE: begin
        mem.addr    = dst_ptr_q;
        mem.wr_en   = 1'b1;
        mem.data_in = buf_q;
      end
      ST_DONE: begin
        mem.addr    = dst_ptr_q;
        mem.wr_en   = 1'b0;
        mem.data_in = buf_q;
      end
      default: ;
    endcase
  end

  // Load data always mirrors the memory; the core only trusts it while not stalled
  assign core.data_out = mem.data_out;

  assign stall_o = busy_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb/tb_dmem_copy_engine.sv - self-checking bench for dmem_copy_engine with a behavioural data memory
module tb_dmem_copy_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] src = 8'h00;
  logic [7:0] dst = 8'h00;
  logic [8:0] len = 9'd0;
  logic       stall;
  logic       busy;
  logic       done;

  dmem_copy_engine_if core_bus ();
  dmem_copy_engine_if mem_bus ();

  dmem_copy_engine dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .src_addr_i (src),
    .dst_addr_i (dst),
    .len_i      (len),
    .core       (core_bus),
    .mem        (mem_bus),
    .stall_o    (stall),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on posedge
  logic [7:0] ram [256];
  always @(posedge clk) if (mem_bus.wr_en) ram[mem_bus.addr] <= mem_bus.data_in;
  assign mem_bus.data_out = ram[mem_bus.addr];

  logic [7:0] model [256];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  wr_seen = 0;

  // Scoreboard: every engine write must match the next expected (addr, data)
  always @(negedge clk) begin
    if (!reset && busy && mem_bus.wr_en) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", mem_bus.addr, mon_e.addr);
        check("wr_data", mem_bus.data_in, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_store(input logic [7:0] a, input logic [7:0] d);
    core_bus.addr    = a;
    core_bus.data_in = d;
    core_bus.wr_en   = 1'b1;
    model[a]         = d;
    tick();
    core_bus.wr_en   = 1'b0;
  endtask

  task automatic image_check(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== model[i]) bad++;
    check(name, bad, 0);
  endtask

  typedef struct {
    logic [7:0] src;
    logic [7:0] dst;
    logic [8:0] len;
    bit         interfere;
    int         exp_lat;
    int         nexp;
    logic [7:0] e [4];
  } cp_t;

  typedef struct {
    logic [7:0] addr;
    bit         we;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } pt_t;

  task automatic run_copy(input cp_t c);
    logic [7:0] b;
    logic [7:0] keep90;
    int         lat;
    bit         busy_ok;
    keep90 = model[8'h90];
    for (int i = 0; i < int'(c.len); i++) begin
      b = model[8'(c.src + i)];
      model[8'(c.dst + i)] = b;
      exp_q.push_back('{addr: 8'(c.dst + i), data: b});
    end
    wr_seen = 0;
    src = c.src; dst = c.dst; len = c.len; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 600) begin
      if (!busy || !stall) busy_ok = 1'b0;
      if (c.interfere) begin
        if (lat == 2) begin
          core_bus.addr = 8'h90; core_bus.data_in = 8'hEE; core_bus.wr_en = 1'b1;
          start = 1'b1; src = 8'h00; dst = 8'hC0; len = 9'd2;
        end
        if (lat == 3) start = 1'b0;
        if (lat == 5) core_bus.wr_en = 1'b0;
      end
      tick();
      lat++;
    end
    check("done_latency", lat, c.exp_lat);
    check("busy_window", busy_ok, 1);
    check("busy_at_done", {busy, stall}, 2'b11);
    tick();
    check("after_done", {busy, stall, done}, 3'b000);
    if (c.interfere) begin
      tick();
      check("no_second_copy", busy, 0);
      check("no_core_write_90", ram[8'h90], keep90);
    end
    check("writes_drained", exp_q.size(), 0);
    check("write_count", wr_seen, int'(c.len));
    for (int k = 0; k < c.nexp; k++) check("dst_byte", ram[8'(c.dst + k)], c.e[k]);
    image_check("mem_image");
  endtask

  cp_t        tbl [7];
  pt_t        pt [6];
  logic [7:0] old [8];
  int         changed;

  initial begin
    tbl[0] = '{src: 8'h20, dst: 8'h80, len: 9'd4,   interfere: 0, exp_lat: 9,   nexp: 4, e: '{8'h11, 8'h22, 8'h33, 8'h44}};
    tbl[1] = '{src: 8'h30, dst: 8'h31, len: 9'd0,   interfere: 0, exp_lat: 1,   nexp: 0, e: '{8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[2] = '{src: 8'hFE, dst: 8'h10, len: 9'd4,   interfere: 0, exp_lat: 9,   nexp: 4, e: '{8'hE1, 8'hF2, 8'h03, 8'h14}};
    tbl[3] = '{src: 8'h40, dst: 8'h41, len: 9'd3,   interfere: 0, exp_lat: 7,   nexp: 3, e: '{8'hAB, 8'hAB, 8'hAB, 8'h00}};
    tbl[4] = '{src: 8'h20, dst: 8'hA0, len: 9'd4,   interfere: 1, exp_lat: 9,   nexp: 4, e: '{8'h11, 8'h22, 8'h33, 8'h44}};
    tbl[5] = '{src: 8'h60, dst: 8'h60, len: 9'd5,   interfere: 0, exp_lat: 11,  nexp: 0, e: '{8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[6] = '{src: 8'h00, dst: 8'h80, len: 9'd256, interfere: 0, exp_lat: 513, nexp: 0, e: '{8'h00, 8'h00, 8'h00, 8'h00}};

    pt[0] = '{addr: 8'h10, we: 1, wdata: 8'h5A, exp_rdata: 8'h00};
    pt[1] = '{addr: 8'h10, we: 0, wdata: 8'h00, exp_rdata: 8'h5A};
    pt[2] = '{addr: 8'hB0, we: 1, wdata: 8'hC3, exp_rdata: 8'h00};
    pt[3] = '{addr: 8'hB1, we: 1, wdata: 8'h3C, exp_rdata: 8'h00};
    pt[4] = '{addr: 8'hB0, we: 0, wdata: 8'h00, exp_rdata: 8'hC3};
    pt[5] = '{addr: 8'hB1, we: 0, wdata: 8'h00, exp_rdata: 8'h3C};

    core_bus.addr = 8'h42; core_bus.wr_en = 1'b0; core_bus.data_in = 8'h00;
    reset = 1'b1;
    tick(); tick(); tick();
    check("rst_flags", {busy, done, stall}, 3'b000);
    check("rst_passthru_addr", mem_bus.addr, 8'h42);
    check("rst_passthru_we", mem_bus.wr_en, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 256; i++) core_store(8'(i), 8'(i * 7 + 3));
    core_store(8'h20, 8'h11); core_store(8'h21, 8'h22);
    core_store(8'h22, 8'h33); core_store(8'h23, 8'h44);
    core_store(8'hFE, 8'hE1); core_store(8'hFF, 8'hF2);
    core_store(8'h00, 8'h03); core_store(8'h01, 8'h14);
    core_store(8'h40, 8'hAB);
    image_check("preload_image");

    for (int i = 0; i < 6; i++) begin
      core_bus.addr = pt[i].addr; core_bus.wr_en = pt[i].we; core_bus.data_in = pt[i].wdata;
      if (pt[i].we) model[pt[i].addr] = pt[i].wdata;
      #1;
      check("pt_addr", mem_bus.addr, pt[i].addr);
      check("pt_we", mem_bus.wr_en, pt[i].we);
      check("pt_stall", stall, 0);
      if (pt[i].we) check("pt_wdata", mem_bus.data_in, pt[i].wdata);
      else check("pt_rdata", core_bus.data_out, pt[i].exp_rdata);
      tick();
    end
    core_bus.wr_en = 1'b0;

    for (int k = 0; k < 8; k++) old[k] = model[8'(8'hD0 + k)];
    for (int k = 0; k < 2; k++) begin
      model[8'(8'hD0 + k)] = model[8'(8'h50 + k)];
      exp_q.push_back('{addr: 8'(8'hD0 + k), data: model[8'(8'h50 + k)]});
    end
    wr_seen = 0;
    src = 8'h50; dst = 8'hD0; len = 9'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    check("rst_mid_flags", {busy, done, stall}, 3'b000);
    reset = 1'b0;
    changed = 0;
    for (int k = 0; k < 8; k++) if (ram[8'(8'hD0 + k)] !== old[k]) changed++;
    check("rst_mid_changed", changed, 2);
    check("rst_mid_writes", wr_seen, 2);
    check("rst_mid_drained", exp_q.size(), 0);
    exp_q.delete();
    core_store(8'h30, 8'h77);
    core_bus.addr = 8'h30;
    #1;
    check("rst_mid_core_load", core_bus.data_out, 8'h77);
    tick();
    image_check("rst_mid_image");

    for (int i = 0; i < 7; i++) run_copy(tbl[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
